// File: rtl/fifo_pkg.sv
// Shared constants and types for the BRISC first-in first-out queue.
package fifo_pkg;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 2;

    // Value loaded into every storage word on reset.
    localparam logic [63:0] RST_DATA = 64'h0;

    // Strobes after qualification by enable.
    typedef struct packed {
        logic we;
        logic re;
        logic clr;
    } fifo_req_t;

    typedef struct packed {
        logic ovf;
        logic unf;
    } fifo_err_t;

endpackage

// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and sticky error bookkeeping for the fifo storage array.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int aw = AW_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  fifo_req_t       req_i,
    output logic            wr_acc_o,
    output logic [aw-1:0]   wp_o,
    output logic [aw-1:0]   rp_o,
    output logic [aw:0]     count_o,
    output logic            full_o,
    output logic            empty_o,
    output fifo_err_t       err_o
);

    localparam logic [aw:0] FULL_CNT = {1'b1, {aw{1'b0}}};

    logic [aw-1:0] wp_q, wp_d;
    logic [aw-1:0] rp_q, rp_d;
    logic [aw:0]   cnt_q, cnt_d;
    fifo_err_t     err_q, err_d;
    logic          full, empty;
    logic          wr_acc, rd_acc;

    // Status comes only from the count; pointers alias when full or empty.
    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == '0);

    // A simultaneous read frees the slot, so a full queue still takes the write.
    assign wr_acc = req_i.we & (~full | req_i.re);
    assign rd_acc = req_i.re & ~empty;

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        err_d = err_q;
        if (wr_acc) wp_d = wp_q + 1'b1;
        if (rd_acc) rp_d = rp_q + 1'b1;
        case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        // Clear first so a same-cycle set event overrides it.
        if (req_i.clr) err_d = '0;
        if (req_i.we & ~wr_acc) err_d.ovf = 1'b1;
        if (req_i.re & empty)   err_d.unf = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            err_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign wr_acc_o = wr_acc;
    assign wp_o     = wp_q;
    assign rp_o     = rp_q;
    assign count_o  = cnt_q;
    assign full_o   = full;
    assign empty_o  = empty;
    assign err_o    = err_q;

endmodule

// File: rtl/fifo.sv
// First-word fall-through queue: storage array plus read mux around fifo_ctrl.
module fifo
    import fifo_pkg::*;
#(
    parameter int dw = DW_DEF,
    parameter int aw = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          wr_en,
    input  logic [dw-1:0] din,
    input  logic          rd_en,
    output logic [dw-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [aw:0]   count,
    output logic          overflow,
    output logic          underflow,
    input  logic          clr_err
);

    localparam int          DEPTH    = 2 ** aw;
    localparam logic [dw-1:0] RST_WORD = RST_DATA[dw-1:0];

    fifo_req_t                  req;
    fifo_err_t                  err;
    logic                       wr_acc;
    logic [aw-1:0]              wp, rp;
    logic [DEPTH-1:0][dw-1:0]   mem_q;

    assign req.we  = enable & wr_en;
    assign req.re  = enable & rd_en;
    assign req.clr = enable & clr_err;

    fifo_ctrl #(.aw(aw)) u_ctrl (
        .clk      (clk),
        .reset    (reset),
        .req_i    (req),
        .wr_acc_o (wr_acc),
        .wp_o     (wp),
        .rp_o     (rp),
        .count_o  (count),
        .full_o   (full),
        .empty_o  (empty),
        .err_o    (err)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q <= {DEPTH{RST_WORD}};
        end else if (wr_acc) begin
            mem_q[wp] <= din;
        end
    end

    // Head is read straight from storage; a write never bypasses to dout.
    assign dout      = mem_q[rp];
    assign overflow  = err.ovf;
    assign underflow = err.unf;

endmodule
